cdb_rr_scheduler: RTL
=====================

# cdb_rr_scheduler

Round-robin scheduler for the Common Data Bus (CDB) in the Tomasulo core. It accepts finished results from NUM_UF functional units (ADD1, ADD2, …) and grants the single CDB to one unit per cycle. It broadcasts the winner's reservation-station tag and data, registered, to the register status table and to every reservation station / operand selector. Fairness is guaranteed: no requester waits more than NUM_UF-1 broadcasts.

## Interface
- NUM_UF, 4, number of requesting functional units (2..8)
- DATA_W, 16, result width
- TAG_W, 4, reservation-station tag width; tag 0 = FREE_REGISTER (no producer)
- Clock  in  1  rising-edge clock
- Reset  in  1  reset Reset, asynchronous, active-high
- Flush  in  1  synchronous squash: cancels arbitration this edge, resets pointer
- Req  in  NUM_UF  per-unit result-ready request, level
- Req_tag  in  NUM_UF*TAG_W  unit i tag at [i*TAG_W +: TAG_W]
- Req_data  in  NUM_UF*DATA_W  unit i result at [i*DATA_W +: DATA_W]
- Grant  out  NUM_UF  one-hot registered pulse; unit i's result is on the CDB this cycle
- Cdb_valid  out  1  broadcast valid
- Cdb_tag  out  TAG_W  broadcast tag (Qi_CDB)
- Cdb_data  out  DATA_W  broadcast data (Qi_CDB_data); SEM_VALOR when not valid
- Cdb_src  out  3  index of granted unit
- Err_tag  out  1  sticky: a request arrived with tag 0
- Bcast_count  out  16  number of valid broadcasts, wraps at 0xFFFF→0

## Operation
- Eligible[i] = Req[i] & ~Grant[i]. The unit granted last cycle is masked, so a held Req is never granted twice for one result.
- Each edge without Flush: search Eligible starting at ptr, ascending, wrapping at NUM_UF-1→0. The first hit w wins.
- On a win: Grant ← onehot(w), Cdb_tag ← Req_tag[w], Cdb_data ← Req_data[w], Cdb_src ← w, ptr ← (w+1) mod NUM_UF.
- If Req_tag[w] ≠ 0: Cdb_valid ← 1 and Bcast_count increments.
- If Req_tag[w] = 0: Grant still pulses so the unit drains. Cdb_valid ← 0, Cdb_data ← SEM_VALOR, Err_tag ← 1.
- No hit: Grant ← 0, Cdb_valid ← 0, Cdb_tag ← 0, Cdb_data ← SEM_VALOR, Cdb_src unchanged, ptr unchanged.
- Flush high: same outputs as "no hit", and ptr ← 0. A Flush-cancelled request stays pending if Req is held. Err_tag and Bcast_count are unaffected.
- Requester contract:
  - Hold Req, tag and data stable until Grant[i] is seen.
  - Drop Req, or present the next result, on the edge after Grant.
  - Per-unit throughput is therefore at most 1 result / 2 cycles; bus throughput is 1 / cycle.
- State: ptr (log2 NUM_UF bits), output registers, Err_tag, Bcast_count. The FSM is implicit: IDLE (Cdb_valid=0) / BCAST (Cdb_valid=1), re-decided every edge.

## Timing
- Reset values: Grant 0, Cdb_valid 0, Cdb_tag 0, Cdb_data SEM_VALOR (16'hFFF0), Cdb_src 0, Err_tag 0, Bcast_count 0, ptr 0.
- Latency: Req sampled at edge k → Grant and CDB valid during cycle k..k+1. Consumers capture at edge k+1.
- A Req that rises in the same cycle another unit is granted competes at the next edge.
- Reset asserted mid-broadcast clears all outputs immediately (async). The interrupted result is lost unless the unit re-requests.
- Simultaneous requests: the winner is the nearest index at or after ptr.
- Worst-case wait with all units requesting continuously: NUM_UF-1 broadcasts before grant.

## Structure
- tomasulo_pkg holds:
  - SEM_VALOR = 16'hFFF0
  - FREE_REGISTER = 0
  - RES_STATION_ADD1 = 1, RES_STATION_ADD2 = 2, …
  - default TAG_W / DATA_W
- Sub-module rr_picker (combinational): inputs Eligible and ptr; outputs hit and w, via rotate + find-first + un-rotate.
- cdb_rr_scheduler holds all registers, the masking logic, the error flag and the counter.

## Test plan
- Reset: assert Reset mid-cycle → all outputs at reset values before the next edge; Cdb_data = 16'hFFF0.
- Single request: Req=0001, tag 1, data 16'h0007 → next cycle Grant=0001, Cdb_valid=1, Cdb_tag=1, Cdb_data=0007. With Req still held → following cycle Grant=0, Cdb_valid=0 (no double grant).
- Contention: Req=1111 held continuously, tags 1..4 → grant order 0,1,2,3,0,… with one broadcast per cycle. After 8 broadcasts, Bcast_count=8.
- Pointer wrap: grant unit 3, then Req=1001 → unit 0 granted next, then unit 3.
- Tag-zero request: Req=0100, tag 0 → Grant=0100, Cdb_valid=0, Err_tag=1, which stays set after Req drops.
- Flush: Req=0010 with Flush=1 for one edge → no grant. Next edge → Grant=0010. After Flush, ptr=0, so Req=1010 grants unit 1 before unit 3.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// rtl/tomasulo_pkg.sv - shared Tomasulo core constants and CDB scheduler types
package tomasulo_pkg;

    localparam int DEFAULT_TAG_W  = 4;
    localparam int DEFAULT_DATA_W = 16;

    // Data value driven on the bus whenever no valid result is broadcast
    localparam logic [15:0] SEM_VALOR = 16'hFFF0;

    localparam logic [DEFAULT_TAG_W-1:0] FREE_REGISTER    = 4'd0;
    localparam logic [DEFAULT_TAG_W-1:0] RES_STATION_ADD1 = 4'd1;
    localparam logic [DEFAULT_TAG_W-1:0] RES_STATION_ADD2 = 4'd2;
    localparam logic [DEFAULT_TAG_W-1:0] RES_STATION_ADD3 = 4'd3;
    localparam logic [DEFAULT_TAG_W-1:0] RES_STATION_ADD4 = 4'd4;

    typedef enum logic {
        CDB_IDLE  = 1'b0,
        CDB_BCAST = 1'b1
    } cdb_state_t;

endpackage

// File: rtl/cdb_rr_scheduler_picker.sv
// rtl/cdb_rr_scheduler_picker.sv - combinational round-robin find-first from a start pointer
module rr_picker #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     eligible,
    input  logic [PTR_W-1:0] ptr,
    output logic             hit,
    output logic [PTR_W-1:0] w
);

    localparam logic [PTR_W:0] N_W = (PTR_W+1)'(N);

    logic [2*N-1:0]   doubled;
    logic [N-1:0]     rotated;
    logic [PTR_W-1:0] offset;
    logic [PTR_W:0]   sum;

    // Rotate so ptr lands at bit 0, take the lowest set bit, then rotate the index back
    always_comb begin
        doubled = {eligible, eligible};
        rotated = doubled[ptr +: N];
        hit     = 1'b0;
        offset  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                hit    = 1'b1;
                offset = PTR_W'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, offset};
        if (sum >= N_W) begin
            sum = sum - N_W;
        end
        w = sum[PTR_W-1:0];
    end

endmodule

// File: rtl/cdb_rr_scheduler.sv
// rtl/cdb_rr_scheduler.sv - round-robin arbiter granting the common data bus to one unit per cycle
module cdb_rr_scheduler
    import tomasulo_pkg::*;
#(
    parameter int NUM_UF = 4,
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int TAG_W  = DEFAULT_TAG_W
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Flush,
    input  logic [NUM_UF-1:0]        Req,
    input  logic [NUM_UF*TAG_W-1:0]  Req_tag,
    input  logic [NUM_UF*DATA_W-1:0] Req_data,
    output logic [NUM_UF-1:0]        Grant,
    output logic                     Cdb_valid,
    output logic [TAG_W-1:0]         Cdb_tag,
    output logic [DATA_W-1:0]        Cdb_data,
    output logic [2:0]               Cdb_src,
    output logic                     Err_tag,
    output logic [15:0]              Bcast_count
);

    localparam int PTR_W = $clog2(NUM_UF);
    localparam logic [DATA_W-1:0] IDLE_DATA = DATA_W'(SEM_VALOR);
    localparam logic [NUM_UF-1:0] ONE_HOT0  = NUM_UF'(1);

    cdb_state_t        state;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  w;
    logic [PTR_W-1:0]  ptr_next;
    logic              hit;
    logic [NUM_UF-1:0] eligible;
    logic [TAG_W-1:0]  win_tag;
    logic [DATA_W-1:0] win_data;

    // The unit holding the bus this cycle is masked so a held Req cannot win twice
    assign eligible = Req & ~Grant;
    assign win_tag  = Req_tag[w*TAG_W +: TAG_W];
    assign win_data = Req_data[w*DATA_W +: DATA_W];
    assign ptr_next = (w == PTR_W'(NUM_UF - 1)) ? '0 : w + 1'b1;
    assign Cdb_valid = (state == CDB_BCAST);

    rr_picker #(
        .N     (NUM_UF),
        .PTR_W (PTR_W)
    ) u_picker (
        .eligible (eligible),
        .ptr      (ptr),
        .hit      (hit),
        .w        (w)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state       <= CDB_IDLE;
            ptr         <= '0;
            Grant       <= '0;
            Cdb_tag     <= '0;
            Cdb_data    <= IDLE_DATA;
            Cdb_src     <= '0;
            Err_tag     <= 1'b0;
            Bcast_count <= '0;
        end else if (Flush) begin
            state    <= CDB_IDLE;
            ptr      <= '0;
            Grant    <= '0;
            Cdb_tag  <= '0;
            Cdb_data <= IDLE_DATA;
        end else if (hit) begin
            Grant   <= ONE_HOT0 << w;
            Cdb_tag <= win_tag;
            Cdb_src <= 3'(w);
            ptr     <= ptr_next;
            if (win_tag != TAG_W'(FREE_REGISTER)) begin
                state       <= CDB_BCAST;
                Cdb_data    <= win_data;
                Bcast_count <= Bcast_count + 16'd1;
            end else begin
                // Tag-zero results drain the unit but never reach consumers
                state    <= CDB_IDLE;
                Cdb_data <= IDLE_DATA;
                Err_tag  <= 1'b1;
            end
        end else begin
            state    <= CDB_IDLE;
            Grant    <= '0;
            Cdb_tag  <= '0;
            Cdb_data <= IDLE_DATA;
        end
    end

endmodule
